// File: rtl/wb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : wb_cmd_master
// Description : Single-beat Wishbone classic initiator driven by a valid/ready
//               command channel, with a bus-timeout watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_cmd_master #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255,
    localparam int SW     = DW / 8
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_adr,
    input  logic [DW-1:0] cmd_dat,
    input  logic [SW-1:0] cmd_sel,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_dat,
    output logic [1:0]    rsp_status,
    output logic          wbm_cyc_o,
    output logic          wbm_stb_o,
    output logic          wbm_we_o,
    output logic [SW-1:0] wbm_sel_o,
    output logic [AW-1:0] wbm_adr_o,
    output logic [DW-1:0] wbm_dat_o,
    input  logic          wbm_ack_i,
    input  logic          wbm_err_i,
    input  logic [DW-1:0] wbm_dat_i,
    output logic          busy
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] c_TMO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [1:0] c_ST_OK  = 2'b00;
    localparam logic [1:0] c_ST_ERR = 2'b01;
    localparam logic [1:0] c_ST_TMO = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic          r_cmd_ready;
    logic          r_rsp_valid;
    logic [DW-1:0] r_rsp_dat;
    logic [1:0]    r_rsp_status;
    logic          r_cyc;
    logic          r_stb;
    logic          r_we;
    logic [SW-1:0] r_sel;
    logic [AW-1:0] r_adr;
    logic [DW-1:0] r_dat;
    logic [CW-1:0] r_cnt;

    logic          w_accept;
    logic          w_timeout;
    logic          w_term;
    logic [1:0]    w_status;
    logic [DW-1:0] w_dat;

    assign w_accept  = (r_state == IDLE) && cmd_valid && r_cmd_ready;
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == c_TMO_LAST);

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Termination priority: err beats ack, ack beats the watchdog.
    always_comb begin
        w_next   = r_state;
        w_term   = 1'b0;
        w_status = c_ST_OK;
        w_dat    = '0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = BUS;
                end
            end
            BUS: begin
                if (wbm_err_i) begin
                    w_term   = 1'b1;
                    w_status = c_ST_ERR;
                end else if (wbm_ack_i) begin
                    w_term   = 1'b1;
                    w_status = c_ST_OK;
                    w_dat    = r_we ? '0 : wbm_dat_i;
                end else if (w_timeout) begin
                    w_term   = 1'b1;
                    w_status = c_ST_TMO;
                end
                if (w_term) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_cmd_ready  <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_dat    <= '0;
            r_rsp_status <= 2'b00;
            r_cyc        <= 1'b0;
            r_stb        <= 1'b0;
            r_we         <= 1'b0;
            r_sel        <= '0;
            r_adr        <= '0;
            r_dat        <= '0;
            r_cnt        <= '0;
        end else begin
            // Registered so ready reappears one cycle after the response handshake.
            r_cmd_ready <= (r_state == IDLE) && !w_accept;
            if (w_accept) begin
                r_cyc <= 1'b1;
                r_stb <= 1'b1;
                r_we  <= cmd_we;
                r_sel <= cmd_sel;
                r_adr <= cmd_adr;
                r_dat <= cmd_dat;
                r_cnt <= '0;
            end
            if (r_state == BUS) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_term) begin
                    r_cyc        <= 1'b0;
                    r_stb        <= 1'b0;
                    r_we         <= 1'b0;
                    r_sel        <= '0;
                    r_dat        <= '0;
                    r_rsp_valid  <= 1'b1;
                    r_rsp_dat    <= w_dat;
                    r_rsp_status <= w_status;
                end
            end
            if ((r_state == RESP) && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_dat    = r_rsp_dat;
    assign rsp_status = r_rsp_status;
    assign wbm_cyc_o  = r_cyc;
    assign wbm_stb_o  = r_stb;
    assign wbm_we_o   = r_we;
    assign wbm_sel_o  = r_sel;
    assign wbm_adr_o  = r_adr;
    assign wbm_dat_o  = r_dat;
    assign busy       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_wb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_cmd_master
// Description : Directed self-checking bench for wb_cmd_master (TIMEOUT=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_cmd_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic [1:0]  rsp_status;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_o;
    logic        ack;
    logic        err;
    logic [31:0] dat_i;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_cmd_master #(
        .AW      (32),
        .DW      (32),
        .TIMEOUT (8)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_we     (cmd_we),
        .cmd_adr    (cmd_adr),
        .cmd_dat    (cmd_dat),
        .cmd_sel    (cmd_sel),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_dat    (rsp_dat),
        .rsp_status (rsp_status),
        .wbm_cyc_o  (cyc),
        .wbm_stb_o  (stb),
        .wbm_we_o   (we),
        .wbm_sel_o  (sel),
        .wbm_adr_o  (adr),
        .wbm_dat_o  (dat_o),
        .wbm_ack_i  (ack),
        .wbm_err_i  (err),
        .wbm_dat_i  (dat_i),
        .busy       (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_we    = w;
        cmd_adr   = a;
        cmd_dat   = d;
        cmd_sel   = 4'hF;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic finish_rsp(input string tag);
        rsp_ready = 1'b1;
        tick();
        chk({tag, "_hs_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_hs_ready"}, {31'd0, cmd_ready}, 32'd0);
        rsp_ready = 1'b0;
        tick();
        chk({tag, "_ready_back"}, {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_dat   = '0;
        cmd_sel   = '0;
        rsp_ready = 1'b0;
        ack       = 1'b0;
        err       = 1'b0;
        dat_i     = '0;

        // Reset state
        tick();
        tick();
        chk("rst_cyc",    {31'd0, cyc},       32'd0);
        chk("rst_stb",    {31'd0, stb},       32'd0);
        chk("rst_rspv",   {31'd0, rsp_valid}, 32'd0);
        chk("rst_ready",  {31'd0, cmd_ready}, 32'd0);
        chk("rst_busy",   {31'd0, busy},      32'd0);
        chk("rst_status", {30'd0, rsp_status}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

        // Zero-wait write
        ack = 1'b1;
        send(1'b1, 32'h3000_0004, 32'hCAFE_F00D);
        chk("wr_cyc",   {31'd0, cyc},  32'd1);
        chk("wr_stb",   {31'd0, stb},  32'd1);
        chk("wr_we",    {31'd0, we},   32'd1);
        chk("wr_adr",   adr,           32'h3000_0004);
        chk("wr_dat",   dat_o,         32'hCAFE_F00D);
        chk("wr_sel",   {28'd0, sel},  32'hF);
        chk("wr_busy",  {31'd0, busy}, 32'd1);
        chk("wr_rdy",   {31'd0, cmd_ready}, 32'd0);
        chk("wr_rspv0", {31'd0, rsp_valid}, 32'd0);
        tick();
        ack = 1'b0;
        chk("wr_cyc_drop", {31'd0, cyc},       32'd0);
        chk("wr_rspv",     {31'd0, rsp_valid}, 32'd1);
        chk("wr_status",   {30'd0, rsp_status}, 32'd0);
        chk("wr_rdat",     rsp_dat,            32'd0);
        chk("wr_dat_clr",  dat_o,              32'd0);
        chk("wr_sel_clr",  {28'd0, sel},       32'd0);
        finish_rsp("wr");

        // Read with 3 wait states
        send(1'b0, 32'h3000_0000, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("rd_wait_cyc", {31'd0, cyc}, 32'd1);
            chk("rd_wait_adr", adr,          32'h3000_0000);
            chk("rd_wait_we",  {31'd0, we},  32'd0);
            tick();
        end
        chk("rd_cyc4", {31'd0, cyc}, 32'd1);
        ack   = 1'b1;
        dat_i = 32'h1234_5678;
        tick();
        ack   = 1'b0;
        dat_i = 32'h0;
        chk("rd_cyc_drop", {31'd0, cyc},        32'd0);
        chk("rd_rspv",     {31'd0, rsp_valid},  32'd1);
        chk("rd_rdat",     rsp_dat,             32'h1234_5678);
        chk("rd_status",   {30'd0, rsp_status}, 32'd0);
        finish_rsp("rd");

        // err together with ack
        send(1'b0, 32'h3000_0010, 32'h0);
        ack   = 1'b1;
        err   = 1'b1;
        dat_i = 32'hFFFF_FFFF;
        tick();
        ack   = 1'b0;
        err   = 1'b0;
        dat_i = 32'h0;
        chk("err_cyc",    {31'd0, cyc},        32'd0);
        chk("err_stb",    {31'd0, stb},        32'd0);
        chk("err_status", {30'd0, rsp_status}, 32'd1);
        chk("err_rdat",   rsp_dat,             32'd0);
        finish_rsp("err");

        // ack on the last cycle before timeout
        send(1'b0, 32'h3000_0020, 32'h0);
        for (int i = 0; i < 7; i++) tick();
        chk("late_cyc", {31'd0, cyc}, 32'd1);
        ack   = 1'b1;
        dat_i = 32'hA5A5_A5A5;
        tick();
        ack   = 1'b0;
        dat_i = 32'h0;
        chk("late_status", {30'd0, rsp_status}, 32'd0);
        chk("late_rdat",   rsp_dat,             32'hA5A5_A5A5);
        finish_rsp("late");

        // Timeout, slave silent
        send(1'b0, 32'h3000_0030, 32'h0);
        n = 0;
        while (cyc === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        chk("tmo_cycles", n,                   32'd8);
        chk("tmo_rspv",   {31'd0, rsp_valid},  32'd1);
        chk("tmo_status", {30'd0, rsp_status}, 32'd2);
        chk("tmo_rdat",   rsp_dat,             32'd0);
        finish_rsp("tmo");

        // Backpressure with a command waiting
        ack   = 1'b1;
        dat_i = 32'hDEAD_BEEF;
        send(1'b0, 32'h3000_0040, 32'h0);
        tick();
        ack   = 1'b0;
        dat_i = 32'h0;
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_adr   = 32'h3000_0008;
        cmd_dat   = 32'h1122_3344;
        cmd_sel   = 4'h3;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rspv",   {31'd0, rsp_valid},  32'd1);
            chk("bp_rdat",   rsp_dat,             32'hDEAD_BEEF);
            chk("bp_status", {30'd0, rsp_status}, 32'd0);
            chk("bp_ready",  {31'd0, cmd_ready},  32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp_hs_rspv", {31'd0, rsp_valid}, 32'd0);
        chk("bp_hs_rdy",  {31'd0, cmd_ready}, 32'd0);
        chk("bp_hs_cyc",  {31'd0, cyc},       32'd0);
        tick();
        chk("bp_rdy_up",  {31'd0, cmd_ready}, 32'd1);
        chk("bp_not_yet", {31'd0, cyc},       32'd0);
        tick();
        cmd_valid = 1'b0;
        chk("bp_acc_cyc", {31'd0, cyc},  32'd1);
        chk("bp_acc_adr", adr,           32'h3000_0008);
        chk("bp_acc_dat", dat_o,         32'h1122_3344);
        chk("bp_acc_sel", {28'd0, sel},  32'h3);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("bp2_status", {30'd0, rsp_status}, 32'd0);
        chk("bp2_rspv",   {31'd0, rsp_valid},  32'd1);
        finish_rsp("bp2");

        // Reset while the bus phase is active
        send(1'b0, 32'h3000_0050, 32'h0);
        tick();
        chk("mr_cyc_pre", {31'd0, cyc}, 32'd1);
        rst_n = 1'b0;
        tick();
        chk("mr_cyc",   {31'd0, cyc},       32'd0);
        chk("mr_stb",   {31'd0, stb},       32'd0);
        chk("mr_rspv",  {31'd0, rsp_valid}, 32'd0);
        chk("mr_rdy",   {31'd0, cmd_ready}, 32'd0);
        chk("mr_busy",  {31'd0, busy},      32'd0);
        rst_n = 1'b1;
        ack   = 1'b1;
        tick();
        ack   = 1'b0;
        chk("mr_rdy_up", {31'd0, cmd_ready}, 32'd1);
        chk("mr_stale",  {31'd0, rsp_valid}, 32'd0);
        tick();
        chk("mr_stale2", {31'd0, rsp_valid}, 32'd0);
        chk("mr_idle",   {31'd0, busy},      32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
- Wishbone classic (B4, non-pipelined) initiator that drives a single-beat read or write on a Wishbone slave, such as the user-project slave port, from a simple valid/ready command channel.
- Returns the read data and a status code on a valid/ready response channel.
- Used by debug/bring-up paths (UART or logic-analyzer bridge) to exercise the SoC slave interface from the other end.
- Includes a bus-timeout watchdog so a dead slave cannot hang the bridge.

Parameters:
- AW, 32, address width of cmd_adr and wbm_adr_o.
- DW, 32, data width. Must be a multiple of 8. SW = DW/8 select lines.
- TIMEOUT, 255, maximum cycles the bus phase may last before forced termination. 0 disables the watchdog.

Ports:
- wb_clk_i  in  1  the only clock.
- wb_rst_ni  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  bridge can accept a command.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_adr  in  AW  byte address.
- cmd_dat  in  DW  write data.
- cmd_sel  in  SW  byte selects.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_dat  out  DW  read data; 0 for writes and errors.
- rsp_status  out  2  00 OK, 01 bus error (err_i), 10 timeout.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  write enable.
- wbm_sel_o  out  SW  byte selects.
- wbm_adr_o  out  AW  address.
- wbm_dat_o  out  DW  write data.
- wbm_ack_i  in  1  slave acknowledge.
- wbm_err_i  in  1  slave error.
- wbm_dat_i  in  DW  slave read data.
- busy  out  1  high in BUS or RESP.

Behaviour:
- Single clock wb_clk_i; reset wb_rst_ni is synchronous and active-low. Sampled only on the rising edge.
- Reset values: all outputs 0, with cmd_ready = 0 during reset and 1 in the first cycle after reset deasserts. FSM goes to IDLE and the timeout counter clears to 0.
- FSM has three states: IDLE, BUS, RESP. All outputs are registered or decoded from state only; there is no combinational path from input to output.
- IDLE:
  - cmd_ready = 1.
  - On edge N with cmd_valid & cmd_ready: latch we/adr/dat/sel into wbm_* regs, set cyc = stb = 1, clear the counter, go to BUS.
  - wbm_cyc_o is high from cycle N+1.
- BUS:
  - cmd_ready = 0. cyc/stb and all wbm_* outputs are held stable.
  - The counter increments every cycle.
  - Termination is evaluated each edge, in priority order err_i > ack_i > timeout:
    - err_i: status 01, rsp_dat 0.
    - ack_i: status 00. rsp_dat = wbm_dat_i for a read, 0 for a write.
    - timeout: counter == TIMEOUT-1 with no ack/err (TIMEOUT != 0). Status 10, rsp_dat 0.
  - On termination: cyc = stb = 0 and we/sel/dat cleared on the same edge; rsp_valid = 1; go to RESP.
  - Minimum cycle with a zero-wait-state slave (ack in the first cyc cycle): cyc high exactly 1 cycle; rsp_valid high at cycle N+2.
  - ack arriving on the timeout cycle counts as OK (ack beats timeout).
- RESP:
  - rsp_valid = 1; rsp_dat and rsp_status are held until rsp_ready.
  - On rsp_valid & rsp_ready: rsp_valid = 0, go to IDLE. cmd_ready rises the next cycle, so there is no same-cycle back-to-back; the minimum command period is 4 cycles with a 0-wait slave.
  - ack/err seen while not in BUS are ignored.
- Reset mid-transaction: cyc/stb drop on the reset edge and any pending response is discarded.
- Address and sel are passed through unmodified; no alignment check.
- busy = (state != IDLE).

Test Plan:
- Write: cmd_we=1, adr=0x3000_0004, dat=0xCAFE_F00D, sel=0xF; slave acks in its 1st cycle -> cyc/stb high 1 cycle with those values; rsp_valid 2 cycles after accept; status 00, rsp_dat 0.
- Read with 3 wait states: adr=0x3000_0000; slave returns 0x1234_5678 with ack on its 4th cycle -> cyc high exactly 4 cycles; rsp_dat 0x1234_5678, status 00; outputs stable across the wait states.
- Error and simultaneous terminations:
  - Slave asserts err_i together with ack_i -> status 01, rsp_dat 0, cyc drops the same edge.
  - Separately, ack on cycle TIMEOUT-1 -> status 00.
- Timeout: TIMEOUT=8, slave never responds -> cyc high exactly 8 cycles, then status 10, rsp_dat 0; the next command works normally.
- Backpressure:
  - rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_dat/rsp_status stable, cmd_ready 0 throughout.
  - A command offered meanwhile is not accepted until 1 cycle after the response handshake.
- Reset mid-BUS: drive wb_rst_ni=0 for 1 cycle while cyc is high -> cyc/stb/rsp_valid 0 after that edge; cmd_ready 1 in the first cycle after reset deasserts; no stale response appears.
